alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu.sv | 51 +++++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states, ALUctr codes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_ADDO = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_SUBO = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Turns a requester id into its req_ready bit position.
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu.sv
// Existing combinational 32-bit ALU; code 011 falls back to a plain add.
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [2:0]  ctr,
  output logic [31:0] r,
  output logic        overflow,
  output logic        zero
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        lt_unsigned;
  logic        lt_signed;

  assign sum         = x + y;
  assign diff        = x - y;
  assign add_ovf     = (x[31] == y[31]) && (sum[31] != x[31]);
  assign sub_ovf     = (x[31] != y[31]) && (diff[31] != x[31]);
  assign lt_unsigned = x < y;
  assign lt_signed   = $signed(x) < $signed(y);

  // Result and overflow selection; overflow is only reported by the checked add/sub codes.
  always_comb begin
    r        = sum;
    overflow = 1'b0;
    case (ctr)
      ALU_ADD:  r = sum;
      ALU_ADDO: begin
        r        = sum;
        overflow = add_ovf;
      end
      ALU_OR:   r = x | y;
      ALU_SUB:  r = diff;
      ALU_SUBO: begin
        r        = diff;
        overflow = sub_ovf;
      end
      ALU_SLTU: r = {31'b0, lt_unsigned};
      ALU_SLT:  r = {31'b0, lt_signed};
      default:  r = sum;
    endcase
  end

  assign zero = (r == 32'd0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way request picker. Build macro ALU_ARB_FIXED_PRIO_EN selects fixed
// priority (requester 0 wins ties, pointer ignored); otherwise ties go to pointer.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       pointer,
  output logic       grant_valid,
  output logic       grant
);

  assign grant_valid = |req_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_pointer;
  assign unused_pointer = pointer;

  // Requester 0 wins whenever it is asking.
  always_comb begin
    grant = 1'b0;
    if (!req_valid[0]) grant = 1'b1;
  end
`else
  // A lone requester wins; on a tie the pointer names the winner.
  always_comb begin
    grant = pointer;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = pointer;
    endcase
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: accept, execute one registered cycle,
// hold the tagged response until consumed. Build macro ALU_ARB_FIXED_PRIO_EN
// switches the tie-break from round-robin to fixed priority for requester 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req0_x,
  input  logic [31:0]      req1_x,
  input  logic [31:0]      req0_y,
  input  logic [31:0]      req1_y,
  input  logic [2:0]       req0_ctr,
  input  logic [2:0]       req1_ctr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_r,
  output logic             resp_overflow,
  output logic             resp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic PRIO_INIT_BIT = (PRIO_INIT != 0);

  arb_state_e  state;
  arb_state_e  state_next;

  logic        pointer;
  logic        arb_valid;
  logic        arb_grant;

  logic        load_op;
  logic        load_resp;
  logic        resp_done;

  logic [31:0] op_x;
  logic [31:0] op_y;
  logic [2:0]  op_ctr;
  logic        op_id;

  logic [31:0] alu_r;
  logic        alu_overflow;
  logic        alu_zero;

  rr_arb2 u_arb (
    .req_valid   (req_valid),
    .pointer     (pointer),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // The ALU only ever sees the captured operation.
  alu u_alu (
    .x        (op_x),
    .y        (op_y),
    .ctr      (op_ctr),
    .r        (alu_r),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus handshake strobes; grants are only offered while idle.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    load_op    = 1'b0;
    load_resp  = 1'b0;
    resp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          req_ready  = id_to_onehot(arb_grant);
          load_op    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        load_resp  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winning requester's operands and id at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x   <= 32'd0;
      op_y   <= 32'd0;
      op_ctr <= ALU_ADD;
      op_id  <= 1'b0;
    end else if (load_op) begin
      op_x   <= arb_grant ? req1_x   : req0_x;
      op_y   <= arb_grant ? req1_y   : req0_y;
      op_ctr <= arb_grant ? req1_ctr : req0_ctr;
      op_id  <= arb_grant;
    end
  end

  // Register the ALU outputs at the end of EXEC so the response stays stable while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id       <= 1'b0;
      resp_r        <= 32'd0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
    end else if (load_resp) begin
      resp_id       <= op_id;
      resp_r        <= alu_r;
      resp_overflow <= alu_overflow;
      resp_zero     <= alu_zero;
    end
  end

  // Count consumed responses and hand tie priority to the requester just served's peer.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
      pointer  <= PRIO_INIT_BIT;
    end else if (resp_done) begin
      op_count <= op_count + CNT_W'(1);
      pointer  <= ~resp_id;
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter; honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int TB_PRIO_INIT = 0;
  localparam int TB_CNT_W     = 4;
  localparam int CNT_MOD      = 1 << TB_CNT_W;

  typedef struct {
    logic        id;
    logic [31:0] r;
    logic        ovf;
    logic        zero;
    int          gcyc;
    bit          seen;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [31:0]         req0_x, req1_x, req0_y, req1_y;
  logic [2:0]          req0_ctr, req1_ctr;
  logic                resp_valid, resp_ready, resp_id;
  logic [31:0]         resp_r;
  logic                resp_overflow, resp_zero, busy;
  logic [TB_CNT_W-1:0] op_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   grant_cyc = -1;
  int   done_cyc = -1;
  int   exp_count = 0;
  logic rr_next = (TB_PRIO_INIT != 0);
  bit   mon_en = 0;
  exp_t sb[$];
  int   grant_log[$];

  logic [1:0]  pend = 2'b00;
  logic [31:0] sx[2];
  logic [31:0] sy[2];
  logic [2:0]  sctr[2];
  logic        resp_ready_next = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.PRIO_INIT(TB_PRIO_INIT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req1_x(req1_x), .req0_y(req0_y), .req1_y(req1_y),
    .req0_ctr(req0_ctr), .req1_ctr(req1_ctr), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_r(resp_r),
    .resp_overflow(resp_overflow), .resp_zero(resp_zero), .busy(busy),
    .op_count(op_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference ALU from the opcode definitions, using wide signed arithmetic for overflow.
  function automatic void refAlu(input logic [2:0] ctr, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic ovf, output logic zero);
    longint a, b, full;
    a = longint'($signed(x));
    b = longint'($signed(y));
    ovf = 1'b0;
    case (ctr)
      3'b001: begin full = a + b; r = x + y; ovf = (full != longint'($signed(r))); end
      3'b010: r = x | y;
      3'b100: r = x - y;
      3'b101: begin full = a - b; r = x - y; ovf = (full != longint'($signed(r))); end
      3'b110: r = (x < y) ? 32'd1 : 32'd0;
      3'b111: r = (a < b) ? 32'd1 : 32'd0;
      default: r = x + y;
    endcase
    zero = (r == 32'd0);
  endfunction

  function automatic int expWinner(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 0;
`else
    return rr_next ? 1 : 0;
`endif
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic loadRandom(input int i);
    sctr[i] = 3'($urandom_range(0, 7));
    sx[i]   = randOperand();
    sy[i]   = randOperand();
    pend[i] = 1'b1;
  endtask

  task automatic applyStimulus(input int i, input logic [2:0] ctr, input logic [31:0] x, input logic [31:0] y);
    sctr[i] = ctr;
    sx[i]   = x;
    sy[i]   = y;
    pend[i] = 1'b1;
  endtask

  // One clock: drive held inputs after the edge, then check the grant mid-cycle.
  task automatic stepCycle();
    logic [1:0] exp_ready;
    int         w;
    exp_t       e;
    @(posedge clk);
    #1;
    req_valid  = pend;
    req0_x     = sx[0];   req1_x   = sx[1];
    req0_y     = sy[0];   req1_y   = sy[1];
    req0_ctr   = sctr[0]; req1_ctr = sctr[1];
    resp_ready = resp_ready_next;
    @(negedge clk);
    exp_ready = 2'b00;
    w = 0;
    if (grant_cyc <= done_cyc && cyc > done_cyc && req_valid != 2'b00) begin
      w = expWinner(req_valid);
      exp_ready[w] = 1'b1;
    end
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_ready != 2'b00) begin
      refAlu(sctr[w], sx[w], sy[w], e.r, e.ovf, e.zero);
      e.id   = 1'(w);
      e.gcyc = cyc;
      e.seen = 1'b0;
      sb.push_back(e);
      grant_cyc = cyc;
      grant_log.push_back(w);
      pend[w] = 1'b0;
    end
  endtask

  task automatic waitAll(input int bound);
    int n = 0;
    while ((sb.size() != 0 || pend != 2'b00) && n < bound) begin
      stepCycle();
      n++;
    end
    if (sb.size() != 0 || pend != 2'b00) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d outstanding required 0", sb.size());
    end
    stepCycle();
  endtask

  task automatic resetChecks();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
    checkOutput("rst_resp_r", resp_r, 32'd0);
    checkOutput("rst_resp_overflow", 32'(resp_overflow), 32'd0);
    checkOutput("rst_resp_zero", 32'(resp_zero), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
  endtask

  // Monitor: compares presented responses with the scoreboard head and tracks counters.
  always @(negedge clk) begin
    logic exp_busy;
    if (mon_en && !rst) begin
      exp_busy = (grant_cyc >= 0) && (cyc > grant_cyc) && ((done_cyc < grant_cyc) || (cyc == done_cyc));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("op_count", 32'(op_count), 32'(exp_count));
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          if (!sb[0].seen) begin
            checkOutput("latency", 32'(cyc - sb[0].gcyc), 32'd2);
            sb[0].seen = 1'b1;
          end
          checkOutput("resp_id", 32'(resp_id), 32'(sb[0].id));
          checkOutput("resp_r", resp_r, sb[0].r);
          checkOutput("resp_overflow", 32'(resp_overflow), 32'(sb[0].ovf));
          checkOutput("resp_zero", 32'(resp_zero), 32'(sb[0].zero));
          if (resp_ready) begin
            rr_next   = ~sb[0].id;
            done_cyc  = cyc;
            exp_count = (exp_count + 1) % CNT_MOD;
            void'(sb.pop_front());
          end
        end
      end else if (sb.size() != 0 && sb[0].seen) begin
        checkOutput("resp_valid_held", 32'(resp_valid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_seq[4];
    int n;
    rst = 1'b1;
    req_valid = 2'b00;
    req0_x = 0; req1_x = 0; req0_y = 0; req1_y = 0; req0_ctr = 0; req1_ctr = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin sx[i] = 0; sy[i] = 0; sctr[i] = 0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    resetChecks();
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Both requesters continuously asking: tie-break order and op_count.
    $display("[TB] phase: contention");
    resp_ready_next = 1'b1;
    grant_log.delete();
    loadRandom(0);
    loadRandom(1);
    n = 0;
    while (grant_log.size() < 4 && n < 60) begin
      stepCycle();
      for (int i = 0; i < 2; i++)
        if (!pend[i] && grant_log.size() < 4) loadRandom(i);
      n++;
    end
    pend = 2'b00;
    waitAll(50);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < 4; k++)
      checkOutput("grant_seq", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(exp_seq[k]));
    checkOutput("op_count_after4", 32'(op_count), 32'd4);

    // Directed opcode vectors.
    $display("[TB] phase: directed");
    applyStimulus(0, ALU_ADDO, 32'h7FFF_FFFF, 32'h1);  waitAll(20);
    applyStimulus(0, ALU_ADD,  32'h7FFF_FFFF, 32'h1);  waitAll(20);
    applyStimulus(1, ALU_SUB,  32'h5, 32'h5);          waitAll(20);
    applyStimulus(1, ALU_OR,   32'hF0, 32'h0F);        waitAll(20);
    applyStimulus(0, ALU_SLT,  32'hFFFF_FFFF, 32'h1);  waitAll(20);
    applyStimulus(1, ALU_SLTU, 32'hFFFF_FFFF, 32'h1);  waitAll(20);
    applyStimulus(0, 3'b011,   32'h7FFF_FFFF, 32'h1);  waitAll(20);
    applyStimulus(1, ALU_SUBO, 32'h8000_0000, 32'h1);  waitAll(20);

    // Consumer stalls for five cycles with a second request waiting.
    $display("[TB] phase: backpressure");
    resp_ready_next = 1'b0;
    applyStimulus(0, ALU_SUB, 32'h9, 32'h9);
    applyStimulus(1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    n = 0;
    do begin stepCycle(); n++; end while (!resp_valid && n < 20);
    checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
    repeat (5) begin
      stepCycle();
      checkOutput("hold_busy", 32'(busy), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready_next = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("release_busy", 32'(busy), 32'd0);
    waitAll(30);

    // Random traffic with random backpressure and occasional withdrawn requests.
    $display("[TB] phase: random");
    for (int k = 0; k < 240; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) loadRandom(i);
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
      resp_ready_next = ($urandom_range(0, 3) != 0);
      stepCycle();
    end
    resp_ready_next = 1'b1;
    waitAll(200);

    // Reset while an operation is executing.
    $display("[TB] phase: reset mid-op");
    applyStimulus(0, ALU_ADD, 32'h1, 32'h2);
    n = 0;
    while (pend[0] && n < 20) begin stepCycle(); n++; end
    @(posedge clk);
    #1;
    rst = 1'b1;
    pend = 2'b00;
    req_valid = 2'b00;
    sb.delete();
    exp_count = 0;
    rr_next = (TB_PRIO_INIT != 0);
    grant_cyc = -1;
    done_cyc = -1;
    @(posedge clk);
    #1;
    @(negedge clk);
    resetChecks();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) stepCycle();
    checkOutput("post_reset_op_count", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
